// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the fetch unit: address width, FSM encoding, NOP word.
// The optional FETCH_TIMEOUT_EN watchdog lives in fetch_unit.sv.
`ifndef WIDTH
`define WIDTH 32
`endif

package fetch_unit_pkg;

    localparam int INST_W = 32;
    localparam logic [INST_W-1:0] NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        FU_IDLE = 2'd0,
        FU_WAIT = 2'd1,
        FU_DROP = 2'd2
    } fu_state_e;

    typedef struct packed {
        logic [`WIDTH-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: DEPTH entries of {pc, inst}, synchronous push/pop/clear,
// head reads as zero when empty.
`ifndef WIDTH
`define WIDTH 32
`endif

module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  fetch_entry_t           din,
    output logic [$clog2(DEPTH):0] count,
    output fetch_entry_t           head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;
    fetch_entry_t  mem [DEPTH];

    always_comb begin
        do_pop  = pop && (count != '0);
        do_push = push && ((count != FULL) || do_pop);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; count alone decides which entries are visible.
    always_ff @(posedge clk) begin
        if (rst && !clear && do_push) mem[wr_ptr] <= din;
    end

    assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_unit.sv
// Fetch unit: single-outstanding imem requests, instruction buffer, decode handshake, flush.
// Define FETCH_TIMEOUT_EN to enable the sticky fetch_err watchdog.
`ifndef WIDTH
`define WIDTH 32
`endif

module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [`WIDTH-1:0] pc_in,
    output logic              stall_pc,
    input  logic              flush,
    output logic              imem_req,
    output logic [`WIDTH-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              inst_valid,
    output logic [31:0]       inst,
    output logic [`WIDTH-1:0] inst_pc,
    input  logic              dec_ready,
    output logic              fetch_err
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
        $error("fetch_unit: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
    end

    fu_state_e         state;
    logic [`WIDTH-1:0] req_pc;
    logic [CW-1:0]     count;
    logic              issue;
    logic              push;
    logic              pop;
    fetch_entry_t      head;
    fetch_entry_t      din;

    // NOTE: every always_comb output gets a value on every path, so no latches are inferred.
    always_comb begin
        issue      = (state == FU_IDLE) && (count < FULL) && !flush && rst;
        stall_pc   = !(rst && (issue || flush));
        inst_valid = (count != '0);
        push       = (state == FU_WAIT) && imem_ack && !flush;
        pop        = inst_valid && dec_ready && !flush;
        din.pc     = req_pc;
        din.inst   = imem_rdata;
        inst       = inst_valid ? head.inst : NOP;
        inst_pc    = inst_valid ? head.pc : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= FU_IDLE;
            imem_req  <= 1'b0;
            imem_addr <= '0;
            req_pc    <= '0;
        end else begin
            imem_req <= issue;
            if (issue) begin
                imem_addr <= pc_in;
                req_pc    <= pc_in;
            end
            case (state)
                FU_IDLE: if (issue) state <= FU_WAIT;
                // An ack always closes the request; a flush without one leaves a response to discard.
                FU_WAIT: begin
                    if (imem_ack)   state <= FU_IDLE;
                    else if (flush) state <= FU_DROP;
                end
                FU_DROP: if (imem_ack) state <= FU_IDLE;
                default: state <= FU_IDLE;
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (flush),
        .din   (din),
        .count (count),
        .head  (head)
    );

`ifdef FETCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] timer;

    // Timer counts cycles spent waiting on memory; fetch_err latches as it reaches TIMEOUT.
    always_ff @(posedge clk) begin
        if (!rst) begin
            timer     <= '0;
            fetch_err <= 1'b0;
        end else begin
            if (state == FU_IDLE)           timer <= '0;
            else if (timer != TW'(TIMEOUT)) timer <= timer + 1'b1;
            if (state != FU_IDLE && timer == TW'(TIMEOUT - 1)) fetch_err <= 1'b1;
        end
    end
`else
    assign fetch_err = 1'b0;
`endif

endmodule
